rampa_arranque_param: RTL and testbench



---
 rtl/rampa_arranque_param.sv | 147 ++++++++++++++
 tb/tb_rampa_arranque_param.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rampa_arranque_param.sv
// Soft-start / soft-stop ramp controller with a built-in tick prescaler.
// The level walks one step per dwell period toward a target chosen by the synchronised mode switches.
module rampa_arranque_param #(
    parameter int PRESCALE    = 100000000,
    parameter int N_LEVELS    = 3,
    parameter int PARTIAL_LVL = 2,
    parameter int DWELL_FAST  = 1,
    parameter int DWELL_SLOW  = 3,
    parameter int DWELL_DOWN  = 2,
    localparam int LVL_W      = $clog2(N_LEVELS + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rapido,
    input  logic                lento,
    output logic [N_LEVELS-1:0] lvl_onehot,
    output logic [LVL_W-1:0]    level,
    output logic [1:0]          state,
    output logic                busy,
    output logic                fault,
    output logic                tick
);

    localparam int CNT_W   = $clog2(PRESCALE);
    localparam int DMAX_UP = (DWELL_FAST > DWELL_SLOW) ? DWELL_FAST : DWELL_SLOW;
    localparam int DMAX    = (DMAX_UP > DWELL_DOWN) ? DMAX_UP : DWELL_DOWN;
    localparam int DW_W    = $clog2(DMAX + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        HOLD      = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    logic [CNT_W-1:0] count;
    logic             r_meta;
    logic             rs;
    logic             l_meta;
    logic             ls;
    logic [LVL_W-1:0] target;
    logic [LVL_W-1:0] level_q;
    logic [DW_W-1:0]  dwell;
    logic [DW_W-1:0]  dwell_len;
    logic             moving_q;
    logic             up_q;
    logic             go_up;
    logic             go_down;
    logic             moving;
    logic             reversed;
    state_t           cur_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (count == CNT_W'(PRESCALE - 1)) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick = (count == CNT_W'(PRESCALE - 1));

    // Both requests together is treated as a fault and targets a controlled stop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b0;
            rs     <= 1'b0;
            l_meta <= 1'b0;
            ls     <= 1'b0;
            target <= '0;
            fault  <= 1'b0;
        end else begin
            r_meta <= rapido;
            rs     <= r_meta;
            l_meta <= lento;
            ls     <= l_meta;
            fault  <= rs & ls;
            if (rs && !ls) begin
                target <= LVL_W'(N_LEVELS);
            end else if (ls && !rs) begin
                target <= LVL_W'(PARTIAL_LVL);
            end else begin
                target <= '0;
            end
        end
    end

    assign go_up    = (level_q < target);
    assign go_down  = (level_q > target);
    assign moving   = go_up | go_down;
    assign reversed = moving && moving_q && (go_up != up_q);

    always_comb begin
        dwell_len = DW_W'(DWELL_DOWN);
        if (go_up) begin
            dwell_len = rs ? DW_W'(DWELL_FAST) : DW_W'(DWELL_SLOW);
        end
    end

    // A target crossing the level restarts the dwell so the new direction gets a full period.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_q  <= '0;
            dwell    <= '0;
            moving_q <= 1'b0;
            up_q     <= 1'b0;
        end else begin
            moving_q <= moving;
            up_q     <= go_up;
            if (!moving || reversed) begin
                dwell <= '0;
            end else if (tick) begin
                if (dwell >= dwell_len - DW_W'(1)) begin
                    dwell   <= '0;
                    level_q <= go_up ? level_q + LVL_W'(1) : level_q - LVL_W'(1);
                end else begin
                    dwell <= dwell + DW_W'(1);
                end
            end
        end
    end

    always_comb begin
        cur_state = HOLD;
        if (go_up) begin
            cur_state = RAMP_UP;
        end else if (go_down) begin
            cur_state = RAMP_DOWN;
        end else if (level_q == '0) begin
            cur_state = IDLE;
        end
    end

    always_comb begin
        lvl_onehot = '0;
        for (int i = 0; i < N_LEVELS; i++) begin
            lvl_onehot[i] = (level_q == LVL_W'(i + 1));
        end
    end

    assign level = level_q;
    assign state = cur_state;
    assign busy  = moving;

endmodule

// File: tb/tb_rampa_arranque_param.sv
// Randomised scoreboard bench for rampa_arranque_param: a cycle reference model queues
// expected outputs at each rising edge and a monitor compares them on the falling edge.
module tb_rampa_arranque_param;

    localparam int PRESCALE    = 4;
    localparam int N_LEVELS    = 4;
    localparam int PARTIAL_LVL = 2;
    localparam int DWELL_FAST  = 1;
    localparam int DWELL_SLOW  = 3;
    localparam int DWELL_DOWN  = 2;
    localparam int LVL_W       = $clog2(N_LEVELS + 1);

    logic                clk    = 1'b0;
    logic                reset  = 1'b1;
    logic                rapido = 1'b0;
    logic                lento  = 1'b0;
    logic [N_LEVELS-1:0] lvl_onehot;
    logic [LVL_W-1:0]    level;
    logic [1:0]          state;
    logic                busy;
    logic                fault;
    logic                tick;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int lvl;
        int st;
        bit flt;
        bit tck;
    } exp_t;

    exp_t sb[$];

    int m_cnt, m_lvl, m_tgt, m_acc, m_prev_dir;
    bit m_flt;
    bit r_d1, r_d2, l_d1, l_d2;

    rampa_arranque_param #(
        .PRESCALE   (PRESCALE),
        .N_LEVELS   (N_LEVELS),
        .PARTIAL_LVL(PARTIAL_LVL),
        .DWELL_FAST (DWELL_FAST),
        .DWELL_SLOW (DWELL_SLOW),
        .DWELL_DOWN (DWELL_DOWN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rapido    (rapido),
        .lento     (lento),
        .lvl_onehot(lvl_onehot),
        .level     (level),
        .state     (state),
        .busy      (busy),
        .fault     (fault),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    function automatic int expState(input int lv, input int tg);
        if (lv < tg) return 1;
        if (lv > tg) return 3;
        if (lv == 0) return 0;
        return 2;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit l, input int n);
        @(negedge clk);
        rapido = r;
        lento  = l;
        repeat (n) @(negedge clk);
    endtask

    task automatic waitLevel(input int tgt, input int budget);
        int n;
        n = 0;
        while (int'(level) != tgt && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_level", int'(level), tgt);
    endtask

    // Reference model: inputs reach the mode decision two edges after sampling, the
    // target one edge later; the level moves one step after D ticks spent moving one way.
    initial begin
        forever begin
            bit   tick_was, rs, ls;
            int   dir, dlen;
            exp_t e;
            @(posedge clk);
            if (reset) begin
                m_cnt = 0; m_lvl = 0; m_tgt = 0; m_acc = 0; m_prev_dir = 0; m_flt = 0;
                r_d1 = 0; r_d2 = 0; l_d1 = 0; l_d2 = 0;
            end else begin
                tick_was = (m_cnt == PRESCALE - 1);
                rs = r_d2;
                ls = l_d2;
                dir = (m_tgt > m_lvl) ? 1 : ((m_tgt < m_lvl) ? -1 : 0);
                dlen = (dir > 0) ? (rs ? DWELL_FAST : DWELL_SLOW) : DWELL_DOWN;
                if (dir == 0) begin
                    m_acc = 0;
                end else if (m_prev_dir != 0 && m_prev_dir != dir) begin
                    m_acc = 0;
                end else if (tick_was) begin
                    m_acc++;
                    if (m_acc >= dlen) begin
                        m_lvl += dir;
                        m_acc = 0;
                    end
                end
                m_prev_dir = dir;
                m_tgt = (rs && !ls) ? N_LEVELS : ((ls && !rs) ? PARTIAL_LVL : 0);
                m_flt = rs && ls;
                r_d2 = r_d1; r_d1 = rapido;
                l_d2 = l_d1; l_d1 = lento;
                m_cnt = (m_cnt + 1) % PRESCALE;
            end
            e.lvl = m_lvl;
            e.st  = expState(m_lvl, m_tgt);
            e.flt = m_flt;
            e.tck = (m_cnt == PRESCALE - 1);
            sb.push_back(e);
        end
    end

    // Monitor: one expected record per cycle, compared on the falling edge.
    initial begin
        @(posedge clk);
        forever begin
            exp_t e;
            int   oh;
            @(negedge clk);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL scoreboard_empty at %0t: got no expected record, required one", $time);
            end else begin
                e  = sb.pop_front();
                oh = (e.lvl == 0) ? 0 : (1 << (e.lvl - 1));
                checkOutput("level", int'(level), e.lvl);
                checkOutput("lvl_onehot", int'(lvl_onehot), oh);
                checkOutput("state", int'(state), e.st);
                checkOutput("busy", int'(busy), int'(e.st == 1 || e.st == 3));
                checkOutput("fault", int'(fault), int'(e.flt));
                checkOutput("tick", int'(tick), int'(e.tck));
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset_level", int'(level), 0);
        checkOutput("reset_onehot", int'(lvl_onehot), 0);
        checkOutput("reset_state", int'(state), 0);
        checkOutput("reset_fault", int'(fault), 0);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        // Fast ramp to full, then hold.
        applyStimulus(1'b1, 1'b0, 28);
        checkOutput("fast_full_level", int'(level), 4);
        checkOutput("fast_full_state", int'(state), 2);
        checkOutput("fast_full_onehot", int'(lvl_onehot), 4'b1000);

        // Slow mode from full ramps down to the partial level.
        applyStimulus(1'b0, 1'b1, 30);
        checkOutput("partial_level", int'(level), 2);
        checkOutput("partial_onehot", int'(lvl_onehot), 4'b0010);

        // Off, then slow start switched to fast mid-dwell at level 1.
        applyStimulus(1'b0, 1'b0, 40);
        checkOutput("off_state", int'(state), 0);
        applyStimulus(1'b0, 1'b1, 0);
        waitLevel(1, 60);
        repeat (4) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 20);
        checkOutput("switch_fast_level", int'(level), 4);

        // Fault: controlled ramp to zero, then recovery.
        applyStimulus(1'b1, 1'b1, 3);
        checkOutput("fault_set", int'(fault), 1);
        repeat (40) @(negedge clk);
        checkOutput("fault_level", int'(level), 0);
        checkOutput("fault_state", int'(state), 0);
        applyStimulus(1'b1, 1'b0, 3);
        checkOutput("fault_clear", int'(fault), 0);
        repeat (25) @(negedge clk);
        checkOutput("recover_level", int'(level), 4);

        // Reset in the middle of a ramp-down dwell.
        applyStimulus(1'b0, 1'b0, 0);
        waitLevel(3, 30);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midramp_reset_level", int'(level), 0);
        checkOutput("midramp_reset_state", int'(state), 0);
        reset = 1'b0;

        // Pulses that never span a rising edge must not be seen.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #2 rapido = 1'b1;
            #2 rapido = 1'b0;
            @(posedge clk);
            #2 lento = 1'b1;
            #2 lento = 1'b0;
        end
        applyStimulus(1'b0, 1'b0, 6);
        checkOutput("glitch_level", int'(level), 0);
        checkOutput("glitch_state", int'(state), 0);

        for (int i = 0; i < 30; i++) begin
            int mode;
            mode = int'($urandom_range(0, 3));
            applyStimulus(mode[0], mode[1], int'($urandom_range(1, 40)));
            if ($urandom_range(0, 7) == 0) begin
                reset = 1'b1;
                repeat (int'($urandom_range(1, 2))) @(negedge clk);
                reset = 1'b0;
            end
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
